// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundle of the core-side request/response handshake and the
//               word-addressed data-memory port of the load/store unit.
//   slave  modport : the load/store unit itself
//   master modport : the core + data memory side
//   req_*   : request (valid/ready handshake, we, size, sext, addr, wdata)
//   resp_*  : one-cycle completion pulse with load data and error flag
//   mem_*   : word address, write data, write/read strobes, read data
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Converts byte-addressed byte/half/word loads and stores into
//               word accesses on a memory without byte enables. Sub-word
//               stores run as read-modify-write (IDLE -> RD -> WR).
// Ports       : clock   - rising-edge clock
//               reset_n - asynchronous active-low reset
//               bus     - load_store_unit_if.slave (request, response and
//                         memory port signals)
// Parameters  : ADDR_WIDTH - memory word-address width (default 8)
// Options     : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               requests complete with resp_err instead of being aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    logic [1:0]            state_q,  state_d;
    logic                  we_q,     we_d;
    logic [1:0]            size_q,   size_d;
    logic                  sext_q,   sext_d;
    logic [1:0]            off_q,    off_d;
    logic [ADDR_WIDTH-1:0] waddr_q,  waddr_d;
    logic [31:0]           wdata_q,  wdata_d;
    logic [31:0]           merge_q,  merge_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rerr_q,   rerr_d;
    logic [31:0]           rdata_q,  rdata_d;

    logic                  w_misalign;
    logic                  w_req_err;
    logic [1:0]            w_req_off;
    logic [4:0]            w_shamt;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load;
    logic [31:0]           w_lane_mask;
    logic [31:0]           w_merged;
    logic                  w_unused_addr;

    // Address bits above the memory word range are intentionally discarded.
    assign w_unused_addr = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = (bus.req_size == SZ_BAD) || w_misalign;

    // Byte offset inside the word; misaligned halves/words are forced onto
    // their natural boundary (only reachable when trapping is disabled).
    always_comb begin
        case (bus.req_size)
            SZ_BYTE: w_req_off = bus.req_addr[1:0];
            SZ_HALF: w_req_off = {bus.req_addr[1], 1'b0};
            default: w_req_off = 2'b00;
        endcase
    end

    assign w_shamt   = {off_q, 3'b000};
    assign w_shifted = bus.mem_rdata >> w_shamt;

    always_comb begin
        case (size_q)
            SZ_BYTE: w_load = {{24{sext_q & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: w_load = {{16{sext_q & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = bus.mem_rdata;
        endcase
    end

    // Sub-word store: replace only the addressed lane(s) of the captured word.
    assign w_lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_merged    = (merge_q & ~w_lane_mask) | ((wdata_q << w_shamt) & w_lane_mask);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        sext_d   = sext_q;
        off_d    = off_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sext_d  = bus.req_sext;
                    off_d   = w_req_off;
                    waddr_d = bus.req_addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.req_wdata;
                    if (w_req_err) begin
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    merge_d = bus.mem_rdata;
                    state_d = S_WR;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = w_load;
                    state_d  = S_IDLE;
                end
            end
            S_WR: begin
                rvalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            off_q    <= off_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_err   = rerr_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_read   = (state_q == S_RD);
    assign bus.mem_write  = (state_q == S_WR);
    assign bus.mem_addr   = ((state_q == S_RD) || (state_q == S_WR)) ? 32'(waddr_q) : 32'h0;
    assign bus.mem_wdata  = (state_q != S_WR)   ? 32'h0   :
                            (size_q == SZ_WORD) ? wdata_q : w_merged;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed vector
//               table, hand-written back-to-back and reset-abort sequences,
//               and random requests against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    load_store_unit_if bus();

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Data memory: 256 words, synchronous write, asynchronous read. When not
    // read the bus carries a junk pattern so stray sampling is visible.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:0]] : 32'hDEAD_0BAD;

    always @(posedge clock) begin
        if (pre_we)             mem[pre_addr]          <= pre_data;
        else if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    // Protocol monitor: read/write exclusive, idle bus driven to zero,
    // active address within the memory.
    int mon_bad = 0;
    always @(negedge clock) begin
        if ((bus.mem_read && bus.mem_write) ||
            (!bus.mem_read && !bus.mem_write && (bus.mem_addr != 0 || bus.mem_wdata != 0)) ||
            ((bus.mem_read || bus.mem_write) && bus.mem_addr > 32'd255))
            mon_bad++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: little-endian byte array -------------
    logic [7:0] ref_bytes [1024];

    function automatic void model(input logic we, input logic [1:0] size, input logic sext,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int lat,
                                  output logic [7:0] rdm, output logic [7:0] wrm,
                                  output logic [31:0] maddr);
        int n, base;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err   = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!err && (addr % n) != 0) err = 1'b1;
`endif
        rdata = 32'h0; rdm = 8'h0; wrm = 8'h0; maddr = 32'h0; lat = 1;
        if (err) return;
        base  = int'(addr % 1024);
        base  = base - (base % n);
        maddr = 32'(base / 4);
        if (!we) begin
            for (int i = 0; i < n; i++) rdata = rdata | (32'(ref_bytes[base+i]) << (8*i));
            if (sext && n < 4 && rdata[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8*n));
            lat = 2; rdm = 8'h02;
        end else begin
            for (int i = 0; i < n; i++) ref_bytes[base+i] = 8'(wdata >> (8*i));
            if (n == 4) begin lat = 2; wrm = 8'h02; end
            else        begin lat = 3; rdm = 8'h02; wrm = 8'h04; end
        end
    endfunction

    task automatic preload(input int w, input logic [31:0] val);
        pre_we = 1'b1; pre_addr = 8'(w); pre_data = val;
        @(posedge clock); #1;
        pre_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = 8'(val >> (8*i));
    endtask

    // Issue one request from IDLE; record per-cycle activity after accept.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic [7:0] rdm, output logic [7:0] wrm,
                          output logic [7:0] rdym, output logic [31:0] maddr);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_sext = sext; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        // Scramble fields: the unit must use its registered copy.
        bus.req_we = 1'($urandom); bus.req_size = 2'($urandom); bus.req_sext = 1'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        rdata = 32'h0; err = 1'b0; lat = 0; rdm = 8'h0; wrm = 8'h0; rdym = 8'h0; maddr = 32'h0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (bus.mem_read)  begin rdm[k] = 1'b1; maddr = bus.mem_addr; end
            if (bus.mem_write) begin wrm[k] = 1'b1; maddr = bus.mem_addr; end
            if (bus.req_ready) rdym[k] = 1'b1;
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string nm, input logic we, input logic [1:0] size,
                                 input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                                 input logic [7:0] e_rdm, input logic [7:0] e_wrm,
                                 input logic [31:0] e_maddr);
        logic [31:0] rdata, maddr;
        logic        err;
        int          lat;
        logic [7:0]  rdm, wrm, rdym;
        do_req(we, size, sext, addr, wdata, rdata, err, lat, rdm, wrm, rdym, maddr);
        check({nm, "_rdata"}, rdata, e_rdata);
        check({nm, "_err"},   32'(err), 32'(e_err));
        check({nm, "_lat"},   32'(lat), 32'(e_lat));
        check({nm, "_rdmask"}, 32'(rdm), 32'(e_rdm));
        check({nm, "_wrmask"}, 32'(wrm), 32'(e_wrm));
        check({nm, "_ready"}, 32'(rdym), 32'(8'(1 << e_lat)));
        if (!e_err) check({nm, "_maddr"}, maddr, e_maddr);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [7:0]  rdm;
        logic [7:0]  wrm;
        logic [31:0] maddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat,
                       input logic [7:0] rdm, input logic [7:0] wrm, input logic [31:0] maddr);
        vq.push_back('{we, size, sext, addr, wdata, rdata, err, lat, rdm, wrm, maddr});
    endtask

    initial begin
        logic [31:0] m_rdata, m_maddr, m_rdata2, m_maddr2;
        logic        m_err, m_err2;
        int          m_lat, m_lat2, bad_words;
        logic [7:0]  m_rdm, m_wrm, m_rdm2, m_wrm2;
        logic        r_we, r_sext;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;
        logic [31:0] w;

        reset_n = 1'b0;
        pre_we = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_sext = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        for (int i = 0; i < 256; i++) preload(i, 32'h0);
        preload(0, 32'h80FF_7F01);
        preload(1, 32'h1122_3344);

        // Reset state
        @(negedge clock);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp",  {29'h0, bus.resp_valid, bus.resp_err, bus.mem_read | bus.mem_write}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_maddr", bus.mem_addr | bus.mem_wdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        //  we    size  sx addr         wdata         rdata         err lat rdm    wrm    maddr
        add(1'b0, 2'd0, 1, 32'h0000_0002, 32'h0,        32'hFFFF_FFFF, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd0, 0, 32'h0000_0002, 32'h0,        32'h0000_00FF, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd1, 1, 32'h0000_0002, 32'h0,        32'hFFFF_80FF, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd1, 0, 32'h0000_0000, 32'h0,        32'h0000_7F01, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd0, 1, 32'h0000_0001, 32'h0,        32'h0000_007F, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd0, 1, 32'h0000_0003, 32'h0,        32'hFFFF_FF80, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b1, 2'd2, 0, 32'h0000_0008, 32'hDEADBEEF, 32'h0,         0, 2, 8'h00, 8'h02, 32'd2);
        add(1'b0, 2'd2, 0, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 0, 2, 8'h02, 8'h00, 32'd2);
        add(1'b1, 2'd0, 0, 32'h0000_0005, 32'h0000_00AA, 32'h0,        0, 3, 8'h02, 8'h04, 32'd1);
        add(1'b0, 2'd2, 0, 32'h0000_0004, 32'h0,        32'h1122_AA44, 0, 2, 8'h02, 8'h00, 32'd1);
        add(1'b0, 2'd3, 0, 32'h0000_0004, 32'h0,        32'h0,         1, 1, 8'h00, 8'h00, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(1'b0, 2'd1, 0, 32'h0000_0003, 32'h0,        32'h0,         1, 1, 8'h00, 8'h00, 32'd0);
`else
        add(1'b0, 2'd1, 0, 32'h0000_0003, 32'h0,        32'h0000_80FF, 0, 2, 8'h02, 8'h00, 32'd0);
`endif
        add(1'b1, 2'd1, 0, 32'h0000_000A, 32'h5678_1234, 32'h0,        0, 3, 8'h02, 8'h04, 32'd2);
        add(1'b0, 2'd2, 0, 32'h0000_0008, 32'h0,        32'h1234_BEEF, 0, 2, 8'h02, 8'h00, 32'd2);
        add(1'b0, 2'd2, 0, 32'h0000_0400, 32'h0,        32'h80FF_7F01, 0, 2, 8'h02, 8'h00, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(1'b0, 2'd2, 0, 32'h0000_0406, 32'h0,        32'h0,         1, 1, 8'h00, 8'h00, 32'd0);
`else
        add(1'b0, 2'd2, 0, 32'h0000_0406, 32'h0,        32'h1122_AA44, 0, 2, 8'h02, 8'h00, 32'd1);
`endif
        add(1'b1, 2'd0, 0, 32'h0000_0403, 32'hFFFF_FF55, 32'h0,        0, 3, 8'h02, 8'h04, 32'd0);
        add(1'b0, 2'd1, 1, 32'h0000_0002, 32'h0,        32'h0000_55FF, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b0, 2'd2, 1, 32'h0000_0000, 32'h0,        32'h55FF_7F01, 0, 2, 8'h02, 8'h00, 32'd0);
        add(1'b1, 2'd3, 0, 32'h0000_0008, 32'h0,        32'h0,         1, 1, 8'h00, 8'h00, 32'd0);
        add(1'b0, 2'd2, 0, 32'h0000_0008, 32'h0,        32'h1234_BEEF, 0, 2, 8'h02, 8'h00, 32'd2);

        for (int i = 0; i < vq.size(); i++) begin
            model(vq[i].we, vq[i].size, vq[i].sext, vq[i].addr, vq[i].wdata,
                  m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);
            run_and_check($sformatf("vec%0d", i), vq[i].we, vq[i].size, vq[i].sext, vq[i].addr,
                          vq[i].wdata, vq[i].rdata, vq[i].err, vq[i].lat, vq[i].rdm, vq[i].wrm,
                          vq[i].maddr);
        end

        // Back-to-back: LW then SW with req_valid held high throughout.
        model(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);
        model(1'b1, 2'd2, 1'b0, 32'hC, 32'hCAFE_F00D, m_rdata2, m_err2, m_lat2, m_rdm2, m_wrm2, m_maddr2);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h8;
        @(posedge clock); #1;
        bus.req_we = 1'b1; bus.req_addr = 32'hC; bus.req_wdata = 32'hCAFE_F00D;
        @(negedge clock);
        check("b2b_ready_rd", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        check("b2b_resp1", {bus.resp_valid, bus.req_ready, bus.resp_err}, 3'b110);
        check("b2b_rdata1", bus.resp_rdata, m_rdata);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("b2b_wr", {bus.mem_write, bus.mem_addr[30:0]}, {1'b1, m_maddr2[30:0]});
        @(negedge clock);
        check("b2b_resp2", {bus.resp_valid, bus.resp_err}, 2'b10);
        run_and_check("b2b_readback", 1'b0, 2'd2, 1'b0, 32'hC, 32'h0,
                      32'hCAFE_F00D, 1'b0, 2, 8'h02, 8'h00, 32'd3);
        model(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);

        // Reset during the RD phase of a half store: no write, no response.
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_addr = 32'h4; bus.req_wdata = 32'h0000_BBBB;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("abort_in_rd", 32'(bus.mem_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_async", {bus.mem_read, bus.mem_write, bus.req_ready}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("abort_quiet%0d", k), {bus.mem_write, bus.resp_valid}, 2'b00);
        end
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_release", {bus.req_ready, bus.resp_valid, bus.mem_write}, 3'b100);
        model(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);
        check("abort_model_word", m_rdata, 32'h1122_AA44);
        run_and_check("abort_readback", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0,
                      m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);

        // Random requests against the reference model.
        for (int i = 0; i < 300; i++) begin
            r_we    = 1'($urandom);
            r_size  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_sext  = 1'($urandom);
            r_addr  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            r_wdata = $urandom;
            model(r_we, r_size, r_sext, r_addr, r_wdata, m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);
            run_and_check($sformatf("rnd%0d", i), r_we, r_size, r_sext, r_addr, r_wdata,
                          m_rdata, m_err, m_lat, m_rdm, m_wrm, m_maddr);
        end

        // Final memory image against the model.
        bad_words = 0;
        for (int i = 0; i < 256; i++) begin
            w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
            if (mem[i] !== w) bad_words++;
        end
        check("mem_image_bad_words", 32'(bad_words), 32'd0);
        check("bus_protocol_violations", 32'(mon_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
